// File: rtl/param_soft_cpu_pkg.sv
// Shared definitions for param_soft_cpu: opcodes, FSM states and flag bit positions.
// The SOFTCPU_MUL_EN macro enables OP_MUL in the ALU and core decode.
package soft_cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_INV   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_LOAD  = 4'b0100;
  localparam logic [3:0] OP_JFL   = 4'b0101;
  localparam logic [3:0] OP_JFE   = 4'b0110;
  localparam logic [3:0] OP_JFG   = 4'b0111;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_HALT  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    MEM     = 2'd2,
    HALT    = 2'd3
  } state_e;

  // flags = {negative, zero, carry}
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;

endpackage

// File: rtl/param_soft_cpu_if.sv
// Instruction-fetch and data-memory bus of param_soft_cpu.
// master = sequencer/memory side, slave = core side.
interface param_soft_cpu_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ADDR_WIDTH = 16
);
  localparam int unsigned REG_SEL_W   = $clog2(NUM_REGS);
  localparam int unsigned INSTR_WIDTH = 6 + 2 * DATA_WIDTH + REG_SEL_W;

  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instructionValid;
  logic                   instructionReady;
  logic [ADDR_WIDTH-1:0]  instructionPointer;
  logic                   memRequest;
  logic                   memWrite;
  logic [ADDR_WIDTH-1:0]  memAddress;
  logic [DATA_WIDTH-1:0]  memWriteData;
  logic [DATA_WIDTH-1:0]  memReadData;
  logic                   memAck;
  logic [2:0]             flags;
  logic                   halted;
  logic                   illegalInstruction;

  modport master (
    output instruction, instructionValid, memReadData, memAck,
    input  instructionReady, instructionPointer, memRequest, memWrite,
           memAddress, memWriteData, flags, halted, illegalInstruction
  );

  modport slave (
    input  instruction, instructionValid, memReadData, memAck,
    output instructionReady, instructionPointer, memRequest, memWrite,
           memAddress, memWriteData, flags, halted, illegalInstruction
  );
endinterface

// File: rtl/param_soft_cpu_alu.sv
// Combinational ALU for param_soft_cpu: ADD/SUB/INV, plus MUL when SOFTCPU_MUL_EN is defined.
// Carry passes through unchanged for ops that do not define it.
module soft_cpu_alu
  import soft_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  carry_in,
  output logic [DATA_WIDTH-1:0] result,
  output logic [2:0]            nzc
);
  logic [DATA_WIDTH:0] wide;
  logic                carry;
`ifdef SOFTCPU_MUL_EN
  logic [2*DATA_WIDTH-1:0] prod;
`endif

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = carry_in;
`ifdef SOFTCPU_MUL_EN
    prod   = '0;
`endif
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_WIDTH-1:0];
        carry  = wide[DATA_WIDTH];
      end
      OP_SUB: begin
        // top bit of the extended difference is the borrow
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_WIDTH-1:0];
        carry  = wide[DATA_WIDTH];
      end
      OP_INV: result = ~a;
`ifdef SOFTCPU_MUL_EN
      OP_MUL: begin
        prod   = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        result = prod[DATA_WIDTH-1:0];
        carry  = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
      end
`endif
      default: result = '0;
    endcase
    nzc         = '0;
    nzc[FLAG_N] = result[DATA_WIDTH-1];
    nzc[FLAG_Z] = (result == '0);
    nzc[FLAG_C] = carry;
  end
endmodule

// File: rtl/param_soft_cpu.sv
// Parametrised single-issue soft CPU: register file, fetch/execute/memory FSM.
// SOFTCPU_MUL_EN enables opcode 1010 (MUL); otherwise it decodes as illegal.
module param_soft_cpu
  import soft_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  localparam int unsigned REG_SEL_W   = $clog2(NUM_REGS),
  localparam int unsigned INSTR_WIDTH = 6 + 2 * DATA_WIDTH + REG_SEL_W
) (
  input  logic              clock,
  input  logic              reset,
  param_soft_cpu_if.slave   bus
);
  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  ip_q, ip_d;
  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];
  logic [2:0]             flags_q, flags_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                   halted_q, halted_d;
  logic                   illegal_q, illegal_d;

  logic [3:0]            opcode;
  logic                  mode_a, mode_b;
  logic [DATA_WIDTH-1:0] field_a, field_b;
  logic [REG_SEL_W-1:0]  dest;
  logic [DATA_WIDTH-1:0] operand_a, operand_b, alu_result;
  logic [2:0]            alu_nzc;

  assign {opcode, mode_a, mode_b, field_a, field_b, dest} = instr_q;
  assign operand_a = mode_a ? regs_q[field_a[REG_SEL_W-1:0]] : field_a;
  assign operand_b = mode_b ? regs_q[field_b[REG_SEL_W-1:0]] : field_b;

  soft_cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op       (opcode),
    .a        (operand_a),
    .b        (operand_b),
    .carry_in (flags_q[FLAG_C]),
    .result   (alu_result),
    .nzc      (alu_nzc)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    ip_d        = ip_q;
    regs_d      = regs_q;
    flags_d     = flags_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
    illegal_d   = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.instructionValid) begin
          instr_d = bus.instruction;
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        state_d = FETCH;
        ip_d    = ip_q + 1'b1;
        case (opcode)
          OP_NOP: ;
          OP_ADD, OP_SUB, OP_INV: begin
            regs_d[dest] = alu_result;
            flags_d      = alu_nzc;
          end
`ifdef SOFTCPU_MUL_EN
          OP_MUL: begin
            regs_d[dest] = alu_result;
            flags_d      = alu_nzc;
          end
`endif
          OP_JFL: if (operand_a[DATA_WIDTH-1]) ip_d = ADDR_WIDTH'(field_b);
          OP_JFE: if (operand_a == '0) ip_d = ADDR_WIDTH'(field_b);
          OP_JFG: if (!operand_a[DATA_WIDTH-1] && operand_a != '0) ip_d = ADDR_WIDTH'(field_b);
          OP_LOAD, OP_STORE: begin
            // IP advances only once the access completes in MEM
            state_d     = MEM;
            ip_d        = ip_q;
            mem_req_d   = 1'b1;
            mem_we_d    = (opcode == OP_STORE);
            mem_addr_d  = ADDR_WIDTH'({field_a, field_b});
            mem_wdata_d = regs_q[dest];
          end
          OP_HALT: begin
            state_d  = HALT;
            ip_d     = ip_q;
            halted_d = 1'b1;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      MEM: begin
        if (bus.memAck) begin
          if (!mem_we_q) regs_d[dest] = bus.memReadData;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ip_d      = ip_q + 1'b1;
          state_d   = FETCH;
        end
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH;
      instr_q     <= '0;
      ip_q        <= '0;
      flags_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      ip_q        <= ip_d;
      flags_q     <= flags_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bus.instructionReady   = (state_q == FETCH);
  assign bus.instructionPointer = ip_q;
  assign bus.memRequest         = mem_req_q;
  assign bus.memWrite           = mem_we_q;
  assign bus.memAddress         = mem_addr_q;
  assign bus.memWriteData       = mem_wdata_q;
  assign bus.flags              = flags_q;
  assign bus.halted             = halted_q;
  assign bus.illegalInstruction = illegal_q;
endmodule

// File: tb/tb_param_soft_cpu.sv
// Directed self-checking bench for param_soft_cpu at default parameters.
// Honours SOFTCPU_MUL_EN to pick the expected behaviour of opcode 1010.
module tb_param_soft_cpu;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  param_soft_cpu_if #(.DATA_WIDTH(8), .NUM_REGS(8), .ADDR_WIDTH(16)) bus ();

  param_soft_cpu #(.DATA_WIDTH(8), .NUM_REGS(8), .ADDR_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [24:0] mk(input logic [3:0] op, input logic ma, input logic mb,
                                     input logic [7:0] fa, input logic [7:0] fb,
                                     input logic [2:0] d);
    return {op, ma, mb, fa, fb, d};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one instruction and return 1ns after the accepting edge (core in EXECUTE).
  task automatic issue(input logic [24:0] w);
    int n = 0;
    while (!bus.instructionReady && n < 50) begin
      tick();
      n++;
    end
    compared++;
    if (bus.instructionReady !== 1'b1) begin
      mismatched++;
      $display("FAIL issue_ready: got %b expected 1", bus.instructionReady);
    end
    bus.instruction      = w;
    bus.instructionValid = 1'b1;
    tick();
    bus.instructionValid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    compared++;
    if ({bus.instructionPointer, bus.flags, bus.memRequest, bus.memWrite, bus.halted,
         bus.illegalInstruction, bus.memAddress, bus.memWriteData} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: ip=%h flags=%b req=%b we=%b halt=%b ill=%b addr=%h wd=%h expected all 0",
               bus.instructionPointer, bus.flags, bus.memRequest, bus.memWrite, bus.halted,
               bus.illegalInstruction, bus.memAddress, bus.memWriteData);
    end
    reset = 1'b0;
    tick();
    compared++;
    if (bus.instructionReady !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got %b expected 1", bus.instructionReady);
    end
  endtask

  task automatic test_alu();
    issue(mk(4'b0001, 1'b0, 1'b0, 8'h27, 8'h19, 3'd1));
    compared++;
    if (bus.instructionPointer !== 16'h0000 || bus.instructionReady !== 1'b0) begin
      mismatched++;
      $display("FAIL add_execute: ip=%h ready=%b expected 0000 0", bus.instructionPointer, bus.instructionReady);
    end
    tick();
    compared++;
    if (dut.regs_q[1] !== 8'h40 || bus.flags !== 3'b000 || bus.instructionPointer !== 16'h0001) begin
      mismatched++;
      $display("FAIL add_imm: r1=%h flags=%b ip=%h expected 40 000 0001", dut.regs_q[1], bus.flags, bus.instructionPointer);
    end
    issue(mk(4'b0011, 1'b0, 1'b0, 8'h01, 8'h0F, 3'd1));
    tick();
    compared++;
    if (dut.regs_q[1] !== 8'hF2 || bus.flags !== 3'b101 || bus.instructionPointer !== 16'h0002) begin
      mismatched++;
      $display("FAIL sub_borrow: r1=%h flags=%b ip=%h expected f2 101 0002", dut.regs_q[1], bus.flags, bus.instructionPointer);
    end
  endtask

  task automatic test_jump();
    issue(mk(4'b0101, 1'b1, 1'b0, 8'h01, 8'h3C, 3'd0));
    tick();
    compared++;
    if (bus.instructionPointer !== 16'h003C || bus.flags !== 3'b101) begin
      mismatched++;
      $display("FAIL jfl_taken: ip=%h flags=%b expected 003c 101", bus.instructionPointer, bus.flags);
    end
    issue(mk(4'b0001, 1'b0, 1'b0, 8'h7F, 8'h00, 3'd1));
    tick();
    compared++;
    if (dut.regs_q[1] !== 8'h7F || bus.instructionPointer !== 16'h003D || bus.flags !== 3'b000) begin
      mismatched++;
      $display("FAIL set_7f: r1=%h ip=%h flags=%b expected 7f 003d 000", dut.regs_q[1], bus.instructionPointer, bus.flags);
    end
    issue(mk(4'b0111, 1'b1, 1'b0, 8'h01, 8'h10, 3'd0));
    tick();
    compared++;
    if (bus.instructionPointer !== 16'h0010) begin
      mismatched++;
      $display("FAIL jfg_taken: ip=%h expected 0010", bus.instructionPointer);
    end
    issue(mk(4'b0101, 1'b1, 1'b0, 8'h01, 8'h20, 3'd0));
    tick();
    compared++;
    if (bus.instructionPointer !== 16'h0011) begin
      mismatched++;
      $display("FAIL jfl_not_taken: ip=%h expected 0011", bus.instructionPointer);
    end
    issue(mk(4'b0110, 1'b0, 1'b0, 8'h00, 8'h05, 3'd0));
    tick();
    compared++;
    if (bus.instructionPointer !== 16'h0005) begin
      mismatched++;
      $display("FAIL jfe_taken: ip=%h expected 0005", bus.instructionPointer);
    end
    issue(mk(4'b0110, 1'b1, 1'b0, 8'h01, 8'h30, 3'd0));
    tick();
    compared++;
    if (bus.instructionPointer !== 16'h0006 || bus.flags !== 3'b000) begin
      mismatched++;
      $display("FAIL jfe_not_taken: ip=%h flags=%b expected 0006 000", bus.instructionPointer, bus.flags);
    end
  endtask

  task automatic test_inv_add();
    issue(mk(4'b0010, 1'b0, 1'b0, 8'h55, 8'h00, 3'd0));
    tick();
    compared++;
    if (dut.regs_q[0] !== 8'hAA || bus.flags !== 3'b100 || bus.instructionPointer !== 16'h0007) begin
      mismatched++;
      $display("FAIL inv: r0=%h flags=%b ip=%h expected aa 100 0007", dut.regs_q[0], bus.flags, bus.instructionPointer);
    end
    issue(mk(4'b0001, 1'b1, 1'b1, 8'h00, 8'h00, 3'd2));
    tick();
    compared++;
    if (dut.regs_q[2] !== 8'h54 || bus.flags !== 3'b001 || bus.instructionPointer !== 16'h0008) begin
      mismatched++;
      $display("FAIL add_reg_carry: r2=%h flags=%b ip=%h expected 54 001 0008", dut.regs_q[2], bus.flags, bus.instructionPointer);
    end
  endtask

  task automatic test_mem();
    bus.memAck = 1'b0;
    issue(mk(4'b1000, 1'b0, 1'b0, 8'h12, 8'h34, 3'd2));
    tick();
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (bus.memRequest !== 1'b1 || bus.memWrite !== 1'b1 || bus.memAddress !== 16'h1234 ||
          bus.memWriteData !== 8'h54 || bus.instructionReady !== 1'b0) begin
        mismatched++;
        $display("FAIL store_hold[%0d]: req=%b we=%b addr=%h wd=%h ready=%b expected 1 1 1234 54 0",
                 k, bus.memRequest, bus.memWrite, bus.memAddress, bus.memWriteData, bus.instructionReady);
      end
      if (k == 3) bus.memAck = 1'b1;
      tick();
    end
    bus.memAck = 1'b0;
    compared++;
    if (bus.memRequest !== 1'b0 || bus.instructionPointer !== 16'h0009 || bus.instructionReady !== 1'b1) begin
      mismatched++;
      $display("FAIL store_done: req=%b ip=%h ready=%b expected 0 0009 1", bus.memRequest, bus.instructionPointer, bus.instructionReady);
    end
    issue(mk(4'b0100, 1'b0, 1'b0, 8'h12, 8'h34, 3'd3));
    tick();
    compared++;
    if (bus.memRequest !== 1'b1 || bus.memWrite !== 1'b0 || bus.memAddress !== 16'h1234) begin
      mismatched++;
      $display("FAIL load_req: req=%b we=%b addr=%h expected 1 0 1234", bus.memRequest, bus.memWrite, bus.memAddress);
    end
    bus.memAck      = 1'b1;
    bus.memReadData = 8'h54;
    tick();
    bus.memAck = 1'b0;
    compared++;
    if (dut.regs_q[3] !== 8'h54 || bus.instructionPointer !== 16'h000A || bus.memRequest !== 1'b0) begin
      mismatched++;
      $display("FAIL load_data: r3=%h ip=%h req=%b expected 54 000a 0", dut.regs_q[3], bus.instructionPointer, bus.memRequest);
    end
  endtask

  task automatic test_reset_in_mem();
    issue(mk(4'b0100, 1'b0, 1'b0, 8'h00, 8'h42, 3'd4));
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++;
    if (bus.memRequest !== 1'b0 || bus.instructionPointer !== 16'h0000 || bus.instructionReady !== 1'b1) begin
      mismatched++;
      $display("FAIL mem_reset: req=%b ip=%h ready=%b expected 0 0000 1", bus.memRequest, bus.instructionPointer, bus.instructionReady);
    end
    for (int r = 0; r < 8; r++) begin
      compared++;
      if (dut.regs_q[r] !== 8'h00) begin
        mismatched++;
        $display("FAIL mem_reset_reg[%0d]: got %h expected 00", r, dut.regs_q[r]);
      end
    end
    bus.memAck      = 1'b1;
    bus.memReadData = 8'h99;
    tick();
    bus.memAck = 1'b0;
    compared++;
    if (dut.regs_q[4] !== 8'h00 || bus.instructionPointer !== 16'h0000 || bus.memRequest !== 1'b0) begin
      mismatched++;
      $display("FAIL late_ack: r4=%h ip=%h req=%b expected 00 0000 0", dut.regs_q[4], bus.instructionPointer, bus.memRequest);
    end
  endtask

  task automatic test_mul();
    issue(mk(4'b0001, 1'b0, 1'b0, 8'h33, 8'h00, 3'd5));
    tick();
    issue(mk(4'b1010, 1'b0, 1'b0, 8'h10, 8'h20, 3'd5));
    tick();
`ifdef SOFTCPU_MUL_EN
    compared++;
    if (dut.regs_q[5] !== 8'h00 || bus.flags !== 3'b011 || bus.illegalInstruction !== 1'b0 ||
        bus.instructionPointer !== 16'h0002) begin
      mismatched++;
      $display("FAIL mul: r5=%h flags=%b ill=%b ip=%h expected 00 011 0 0002",
               dut.regs_q[5], bus.flags, bus.illegalInstruction, bus.instructionPointer);
    end
`else
    compared++;
    if (dut.regs_q[5] !== 8'h33 || bus.flags !== 3'b000 || bus.illegalInstruction !== 1'b1 ||
        bus.instructionPointer !== 16'h0002) begin
      mismatched++;
      $display("FAIL illegal_op: r5=%h flags=%b ill=%b ip=%h expected 33 000 1 0002",
               dut.regs_q[5], bus.flags, bus.illegalInstruction, bus.instructionPointer);
    end
`endif
    tick();
    compared++;
    if (bus.illegalInstruction !== 1'b0) begin
      mismatched++;
      $display("FAIL illegal_pulse_end: got %b expected 0", bus.illegalInstruction);
    end
  endtask

  task automatic test_halt();
    issue(mk(4'b1001, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0));
    bus.instruction      = mk(4'b0001, 1'b0, 1'b0, 8'h01, 8'h01, 3'd6);
    bus.instructionValid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      compared++;
      if (bus.halted !== 1'b1 || bus.instructionPointer !== 16'h0002 || bus.instructionReady !== 1'b0) begin
        mismatched++;
        $display("FAIL halt_frozen[%0d]: halted=%b ip=%h ready=%b expected 1 0002 0",
                 k, bus.halted, bus.instructionPointer, bus.instructionReady);
      end
    end
    bus.instructionValid = 1'b0;
    compared++;
    if (dut.regs_q[6] !== 8'h00) begin
      mismatched++;
      $display("FAIL halt_no_exec: r6=%h expected 00", dut.regs_q[6]);
    end
  endtask

  initial begin
    bus.instruction      = '0;
    bus.instructionValid = 1'b0;
    bus.memReadData      = '0;
    bus.memAck           = 1'b0;
    test_reset();
    test_alu();
    test_jump();
    test_inv_add();
    test_mem();
    test_reset_in_mem();
    test_mul();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
